// File: rtl/uart_packet_scheduler_pkg.sv
// Shared definitions for the UART packet scheduler.
//   state_t            : scheduler FSM states
//   UART_BIT_WIDTH_DEF : default width of one UART byte
//   SUBPKT_COUNT       : number of sub-packets a frame packet is split into
//   clog2_min1()       : $clog2 that never returns a zero width
package uart_packet_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int UART_BIT_WIDTH_DEF = 8;
    localparam int SUBPKT_COUNT       = 4;

    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/uart_packet_scheduler_if.sv
// Handshake/data bundle between a frame source, the scheduler and the UART
// transmitter.
//   iValid    : one-cycle strobe, iDataReg holds a new frame packet
//   iDataReg  : packet bytes, index 0 sent first
//   oTxData   : byte offered to the transmitter
//   oTxValid  : oTxData is valid
//   iTxReady  : transmitter accepts a byte this cycle
//   oBusy     : a packet is held
//   oDropCnt  : saturating count of rejected iValid strobes
// master = source/transmitter side, slave = scheduler.
interface uart_packet_scheduler_if
    import uart_packet_scheduler_pkg::*;
#(
    parameter int REG_SIZE       = 36,
    parameter int UART_BIT_WIDTH = UART_BIT_WIDTH_DEF
);

    logic                      iValid;
    logic [UART_BIT_WIDTH-1:0] iDataReg [REG_SIZE];
    logic [UART_BIT_WIDTH-1:0] oTxData;
    logic                      oTxValid;
    logic                      iTxReady;
    logic                      oBusy;
    logic [15:0]               oDropCnt;

    modport master (
        output iValid, iDataReg, iTxReady,
        input  oTxData, oTxValid, oBusy, oDropCnt
    );

    modport slave (
        input  iValid, iDataReg, iTxReady,
        output oTxData, oTxValid, oBusy, oDropCnt
    );

endinterface

// File: rtl/pace_timer.sv
// Loadable down-counter used to space sub-packets.
//   clk, n_rst : clock, async active-low reset
//   load       : load load_val this cycle (takes priority over counting)
//   load_val   : reload value
//   done       : counter is at zero
// The counter holds at zero, so done stays high until the next load.
module pace_timer #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             done
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/uart_packet_scheduler.sv
// Splits a frame packet into four sub-packets and streams its bytes to a
// UART transmitter, with an idle gap between sub-packets.
//   clk, n_rst : clock, async active-low reset
//   bus        : slave side of uart_packet_scheduler_if
//
// state | meaning
// IDLE  | no packet held, waiting for iValid
// SEND  | offering shadow[idx] to the transmitter
// GAP   | idle spacing between sub-packets, pace_timer running
module uart_packet_scheduler
    import uart_packet_scheduler_pkg::*;
#(
    parameter int REG_SIZE       = 36,
    parameter int UART_BIT_WIDTH = UART_BIT_WIDTH_DEF,
    parameter int SUB_GAP_CYCLES = 208333
) (
    input  logic                    clk,
    input  logic                    n_rst,
    uart_packet_scheduler_if.slave  bus
);

    localparam int SUB   = REG_SIZE / SUBPKT_COUNT;
    localparam int IDX_W = clog2_min1(REG_SIZE);
    localparam int SUB_W = clog2_min1(SUB);
    localparam int GAP_W = clog2_min1(SUB_GAP_CYCLES + 1);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(REG_SIZE - 1);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SUB - 1);
    // Loading G-1 and leaving GAP when the counter reads zero gives G idle cycles.
    localparam logic [GAP_W-1:0] GAP_LOAD =
        GAP_W'((SUB_GAP_CYCLES > 0) ? SUB_GAP_CYCLES - 1 : 0);

    state_t                    state, state_n;
    logic [IDX_W-1:0]          idx, idx_n;
    // Position inside the current sub-packet; avoids a modulo on idx.
    logic [SUB_W-1:0]          sub_idx, sub_n;
    logic                      capture;
    logic                      tmr_load;
    logic                      tmr_done;
    logic                      drop_inc;
    logic [UART_BIT_WIDTH-1:0] shadow [REG_SIZE];
    logic [15:0]               drop_cnt;

    pace_timer #(
        .WIDTH (GAP_W)
    ) u_pace_timer (
        .clk      (clk),
        .n_rst    (n_rst),
        .load     (tmr_load),
        .load_val (GAP_LOAD),
        .done     (tmr_done)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        idx_n    = idx;
        sub_n    = sub_idx;
        capture  = 1'b0;
        tmr_load = 1'b0;
        drop_inc = 1'b0;
        case (state)
            IDLE: begin
                if (bus.iValid) begin
                    capture = 1'b1;
                    idx_n   = '0;
                    sub_n   = '0;
                    state_n = SEND;
                end
            end
            SEND: begin
                drop_inc = bus.iValid;
                if (bus.iTxReady) begin
                    if (idx == IDX_LAST) begin
                        idx_n   = '0;
                        sub_n   = '0;
                        state_n = IDLE;
                    end else if (sub_idx == SUB_LAST) begin
                        idx_n = idx + 1'b1;
                        sub_n = '0;
                        if (SUB_GAP_CYCLES > 0) begin
                            tmr_load = 1'b1;
                            state_n  = GAP;
                        end
                    end else begin
                        idx_n = idx + 1'b1;
                        sub_n = sub_idx + 1'b1;
                    end
                end
            end
            GAP: begin
                drop_inc = bus.iValid;
                if (tmr_done) begin
                    state_n = SEND;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            idx      <= '0;
            sub_idx  <= '0;
            drop_cnt <= '0;
            for (int i = 0; i < REG_SIZE; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            idx     <= idx_n;
            sub_idx <= sub_n;
            if (capture) begin
                shadow <= bus.iDataReg;
            end
            if (drop_inc && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

    assign bus.oTxValid = (state == SEND);
    assign bus.oTxData  = (state == SEND) ? shadow[idx] : '0;
    assign bus.oBusy    = (state != IDLE);
    assign bus.oDropCnt = drop_cnt;

endmodule

// File: tb/tb_uart_packet_scheduler.sv
module tb_uart_packet_scheduler;

    localparam int RS  = 36;
    localparam int W   = 8;
    localparam int GAP = 4;

    logic clk = 1'b0;
    logic n_rst;

    always #5 clk = ~clk;

    uart_packet_scheduler_if #(.REG_SIZE(RS), .UART_BIT_WIDTH(W)) bus_g ();
    uart_packet_scheduler_if #(.REG_SIZE(RS), .UART_BIT_WIDTH(W)) bus_z ();

    uart_packet_scheduler #(
        .REG_SIZE(RS), .UART_BIT_WIDTH(W), .SUB_GAP_CYCLES(GAP)
    ) dut_g (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus_g)
    );

    uart_packet_scheduler #(
        .REG_SIZE(RS), .UART_BIT_WIDTH(W), .SUB_GAP_CYCLES(0)
    ) dut_z (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus_z)
    );

    int checks = 0;
    int errors = 0;
    int exp_drop_g = 0;
    logic [7:0] sb_g [$];
    logic [7:0] sb_z [$];

    // Expected oTxValid for one packet with GAP=4, ready held high:
    // 9 valid, 4 idle, repeated; 48 busy cycles in total.
    function automatic logic exp_valid_gap(input int c);
        return (c < 48) && ((c % 13) < 9);
    endfunction

    task automatic start_packet_g(input logic [7:0] base);
        @(negedge clk);
        for (int i = 0; i < RS; i++) begin
            bus_g.iDataReg[i] = base + 8'(i);
            sb_g.push_back(base + 8'(i));
        end
        bus_g.iValid = 1'b1;
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        bus_g.iValid = 1'b0; bus_g.iTxReady = 1'b0;
        bus_z.iValid = 1'b0; bus_z.iTxReady = 1'b0;
        for (int i = 0; i < RS; i++) begin
            bus_g.iDataReg[i] = 8'h00;
            bus_z.iDataReg[i] = 8'h00;
        end
        #2;
        checks++; if (bus_g.oTxValid !== 1'b0) begin errors++; $display("FAIL rst_g_valid got=%b exp=0", bus_g.oTxValid); end
        checks++; if (bus_g.oTxData !== 8'h00) begin errors++; $display("FAIL rst_g_data got=%h exp=00", bus_g.oTxData); end
        checks++; if (bus_g.oBusy !== 1'b0) begin errors++; $display("FAIL rst_g_busy got=%b exp=0", bus_g.oBusy); end
        checks++; if (bus_g.oDropCnt !== 16'h0) begin errors++; $display("FAIL rst_g_drop got=%h exp=0", bus_g.oDropCnt); end
        checks++; if (bus_z.oTxValid !== 1'b0) begin errors++; $display("FAIL rst_z_valid got=%b exp=0", bus_z.oTxValid); end
        checks++; if (bus_z.oBusy !== 1'b0) begin errors++; $display("FAIL rst_z_busy got=%b exp=0", bus_z.oBusy); end
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        exp_drop_g = 0;
    endtask

    task automatic test_basic();
        logic [7:0] exp;
        bus_g.iTxReady = 1'b1;
        start_packet_g(8'h00);
        for (int c = 0; c < 56; c++) begin
            @(negedge clk);
            if (c == 0) bus_g.iValid = 1'b0;
            checks++;
            if (bus_g.oTxValid !== exp_valid_gap(c)) begin
                errors++; $display("FAIL basic_valid c=%0d got=%b exp=%b", c, bus_g.oTxValid, exp_valid_gap(c));
            end
            checks++;
            if (bus_g.oBusy !== (c < 48)) begin
                errors++; $display("FAIL basic_busy c=%0d got=%b exp=%b", c, bus_g.oBusy, (c < 48));
            end
            if (bus_g.oTxValid === 1'b1 && sb_g.size() > 0) begin
                exp = sb_g.pop_front();
                checks++;
                if (bus_g.oTxData !== exp) begin
                    errors++; $display("FAIL basic_data c=%0d got=%h exp=%h", c, bus_g.oTxData, exp);
                end
            end
        end
        checks++;
        if (sb_g.size() != 0) begin errors++; $display("FAIL basic_missing got=%0d left exp=0", sb_g.size()); end
        sb_g.delete();
    endtask

    task automatic test_backpressure();
        logic       prev_stall = 1'b0;
        logic [7:0] prev_data = 8'h00;
        logic [7:0] exp;
        bit         ready;
        bit         done = 1'b0;
        int         c = 0;
        start_packet_g(8'h40);
        while (!done) begin
            @(negedge clk);
            if (c == 0) bus_g.iValid = 1'b0;
            ready = 1'($urandom_range(0, 1));
            bus_g.iTxReady = ready;
            if (prev_stall) begin
                checks++;
                if (bus_g.oTxValid !== 1'b1 || bus_g.oTxData !== prev_data) begin
                    errors++; $display("FAIL bp_hold c=%0d got=%b/%h exp=1/%h", c, bus_g.oTxValid, bus_g.oTxData, prev_data);
                end
            end
            if (bus_g.oTxValid === 1'b1 && ready) begin
                checks++;
                if (sb_g.size() == 0) begin
                    errors++; $display("FAIL bp_extra c=%0d got=%h exp=none", c, bus_g.oTxData);
                end else begin
                    exp = sb_g.pop_front();
                    if (bus_g.oTxData !== exp) begin
                        errors++; $display("FAIL bp_data c=%0d got=%h exp=%h", c, bus_g.oTxData, exp);
                    end
                end
            end
            prev_stall = (bus_g.oTxValid === 1'b1) && !ready;
            prev_data  = bus_g.oTxData;
            c++;
            if (c > 1 && bus_g.oBusy === 1'b0) begin
                done = 1'b1;
            end else if (c > 3000) begin
                checks++; errors++; $display("FAIL bp_timeout got=busy exp=idle");
                done = 1'b1;
            end
        end
        checks++;
        if (sb_g.size() != 0) begin errors++; $display("FAIL bp_lost got=%0d left exp=0", sb_g.size()); end
        sb_g.delete();
        bus_g.iTxReady = 1'b1;
    endtask

    task automatic test_drop();
        logic [7:0] exp;
        bit         drop;
        bus_g.iTxReady = 1'b1;
        start_packet_g(8'h80);
        for (int c = 0; c < 56; c++) begin
            @(negedge clk);
            drop = (c == 5) || (c == 20) || (c == 30) || (c == 47);
            bus_g.iValid = drop;
            if (drop) begin
                for (int i = 0; i < RS; i++) bus_g.iDataReg[i] = 8'hEE;
                exp_drop_g++;
            end
            checks++;
            if (bus_g.oTxValid !== exp_valid_gap(c)) begin
                errors++; $display("FAIL drop_valid c=%0d got=%b exp=%b", c, bus_g.oTxValid, exp_valid_gap(c));
            end
            if (bus_g.oTxValid === 1'b1 && sb_g.size() > 0) begin
                exp = sb_g.pop_front();
                checks++;
                if (bus_g.oTxData !== exp) begin
                    errors++; $display("FAIL drop_data c=%0d got=%h exp=%h", c, bus_g.oTxData, exp);
                end
            end
            if (c == 40) begin
                checks++;
                if (bus_g.oDropCnt !== 16'(exp_drop_g)) begin
                    errors++; $display("FAIL drop_mid got=%0d exp=%0d", bus_g.oDropCnt, exp_drop_g);
                end
            end
        end
        checks++;
        if (bus_g.oDropCnt !== 16'd4) begin errors++; $display("FAIL drop_cnt got=%0d exp=4", bus_g.oDropCnt); end
        checks++;
        if (bus_g.oBusy !== 1'b0) begin errors++; $display("FAIL drop_busy got=%b exp=0", bus_g.oBusy); end
        sb_g.delete();
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp;
        int sent = 0;
        bus_g.iTxReady = 1'b1;
        start_packet_g(8'h10);
        for (int c = 0; c < 100 && sent < 13; c++) begin
            @(negedge clk);
            if (c == 0) bus_g.iValid = 1'b0;
            if (bus_g.oTxValid === 1'b1 && sb_g.size() > 0) begin
                exp = sb_g.pop_front();
                sent++;
                checks++;
                if (bus_g.oTxData !== exp) begin
                    errors++; $display("FAIL rmid_data got=%h exp=%h", bus_g.oTxData, exp);
                end
            end
        end
        checks++;
        if (sent != 13) begin errors++; $display("FAIL rmid_timeout got=%0d bytes exp=13", sent); end
        @(negedge clk);
        n_rst = 1'b0;
        #1;
        exp_drop_g = 0;
        sb_g.delete();
        checks++; if (bus_g.oTxValid !== 1'b0) begin errors++; $display("FAIL rmid_valid got=%b exp=0", bus_g.oTxValid); end
        checks++; if (bus_g.oTxData !== 8'h00) begin errors++; $display("FAIL rmid_txdata got=%h exp=00", bus_g.oTxData); end
        checks++; if (bus_g.oBusy !== 1'b0) begin errors++; $display("FAIL rmid_busy got=%b exp=0", bus_g.oBusy); end
        checks++; if (bus_g.oDropCnt !== 16'(exp_drop_g)) begin errors++; $display("FAIL rmid_drop got=%0d exp=%0d", bus_g.oDropCnt, exp_drop_g); end
        @(negedge clk);
        n_rst = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            checks++;
            if (bus_g.oTxValid !== 1'b0 || bus_g.oBusy !== 1'b0) begin
                errors++; $display("FAIL rmid_resume c=%0d got=%b/%b exp=0/0", c, bus_g.oTxValid, bus_g.oBusy);
            end
        end
        // Reset again and strobe iValid together with the release.
        n_rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < RS; i++) begin
            bus_g.iDataReg[i] = 8'h60 + 8'(i);
            sb_g.push_back(8'h60 + 8'(i));
        end
        bus_g.iValid = 1'b1;
        n_rst = 1'b1;
        for (int c = 0; c < 52; c++) begin
            @(negedge clk);
            if (c == 0) bus_g.iValid = 1'b0;
            checks++;
            if (bus_g.oTxValid !== exp_valid_gap(c)) begin
                errors++; $display("FAIL restart_valid c=%0d got=%b exp=%b", c, bus_g.oTxValid, exp_valid_gap(c));
            end
            if (bus_g.oTxValid === 1'b1 && sb_g.size() > 0) begin
                exp = sb_g.pop_front();
                checks++;
                if (bus_g.oTxData !== exp) begin
                    errors++; $display("FAIL restart_data c=%0d got=%h exp=%h", c, bus_g.oTxData, exp);
                end
            end
        end
        checks++;
        if (sb_g.size() != 0) begin errors++; $display("FAIL restart_missing got=%0d left exp=0", sb_g.size()); end
        sb_g.delete();
    endtask

    task automatic test_no_gap();
        logic [7:0] exp;
        int run = 0;
        bus_z.iTxReady = 1'b1;
        @(negedge clk);
        for (int i = 0; i < RS; i++) begin
            bus_z.iDataReg[i] = 8'hA0 + 8'(i);
            sb_z.push_back(8'hA0 + 8'(i));
        end
        bus_z.iValid = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (c == 0) bus_z.iValid = 1'b0;
            checks++;
            if (bus_z.oTxValid !== (c < 36)) begin
                errors++; $display("FAIL nogap_valid c=%0d got=%b exp=%b", c, bus_z.oTxValid, (c < 36));
            end
            if (bus_z.oTxValid === 1'b1) begin
                run++;
                if (sb_z.size() > 0) begin
                    exp = sb_z.pop_front();
                    checks++;
                    if (bus_z.oTxData !== exp) begin
                        errors++; $display("FAIL nogap_data c=%0d got=%h exp=%h", c, bus_z.oTxData, exp);
                    end
                end
            end
        end
        checks++;
        if (run != 36) begin errors++; $display("FAIL nogap_count got=%0d exp=36", run); end
        checks++;
        if (bus_z.oBusy !== 1'b0) begin errors++; $display("FAIL nogap_busy got=%b exp=0", bus_z.oBusy); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_drop();
        test_reset_mid();
        test_no_gap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/uart_packet_scheduler.md
UART_PACKET_SCHEDULER -- requirements
Module: uart_packet_scheduler

Interface
REQ-001 The block SHALL have parameter REG_SIZE, default 36, total bytes per frame packet; it must be a multiple of 4.
REQ-002 The block SHALL have parameter UART_BIT_WIDTH, default 8, width of one UART byte.
REQ-003 The block SHALL have parameter SUB_GAP_CYCLES, default 208333, idle clk cycles between the four sub-packets (240 Hz spacing at 50 MHz); 0 means no gap.
REQ-004 The block SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-005 The block SHALL have port n_rst, input, 1, reset; it is asynchronous and active-low.
REQ-006 The block SHALL have port iValid, input, 1, one-cycle strobe: iDataReg holds a new frame packet.
REQ-007 The block SHALL have port iDataReg, input, REG_SIZE x UART_BIT_WIDTH unpacked array, packet bytes; index 0 is sent first.
REQ-008 The block SHALL have port oTxData, output, UART_BIT_WIDTH, byte offered to the UART transmitter.
REQ-009 The block SHALL have port oTxValid, output, 1, oTxData is valid.
REQ-010 The block SHALL have port iTxReady, input, 1, transmitter accepts a byte this cycle.
REQ-011 The block SHALL have port oBusy, output, 1, high while a packet is held (any state but IDLE).
REQ-012 The block SHALL have port oDropCnt, output, 16, saturating count of rejected iValid strobes.

Function
REQ-013 The FSM SHALL have states IDLE, SEND, GAP; SUB = REG_SIZE/4 bytes per sub-packet; byte index idx spans 0..REG_SIZE-1.
REQ-014 In IDLE, iValid=1 SHALL capture all REG_SIZE bytes into an internal shadow buffer, set idx=0 and enter SEND on the same edge.
REQ-015 Latency SHALL be one cycle: iValid high at edge N gives oTxValid=1 with buf[0] after edge N.
REQ-016 In SEND, oTxValid SHALL be 1 and oTxData SHALL be buf[idx]; both SHALL stay stable until a transfer (oTxValid and iTxReady both 1 at an edge).
REQ-017 On a transfer with idx=REG_SIZE-1, the FSM SHALL go to IDLE and oTxValid SHALL drop on the same edge.
REQ-018 On a transfer with idx mod SUB = SUB-1 (not last) and SUB_GAP_CYCLES>0, the FSM SHALL increment idx, enter GAP and load gap counter with SUB_GAP_CYCLES-1.
REQ-019 With SUB_GAP_CYCLES=0, REQ-018 SHALL go directly to SEND with idx+1; there SHALL be no bubble.
REQ-020 On any other transfer, the FSM SHALL increment idx and stay in SEND; back-to-back bytes SHALL be possible every cycle.
REQ-021 In GAP, oTxValid SHALL be 0; the counter SHALL decrement each cycle; at 0 the FSM SHALL enter SEND, giving exactly SUB_GAP_CYCLES cycles with oTxValid=0.
REQ-022 iValid while state is not IDLE, including the edge of the final transfer, SHALL be ignored for data, with oDropCnt incremented, saturating at 16'hFFFF.
REQ-023 The shadow buffer SHALL change only on an accepted iValid; iDataReg changes mid-packet SHALL have no effect.
REQ-024 iTxReady SHALL be ignored outside SEND.

Reset
REQ-025 With n_rst=0, the FSM SHALL be in IDLE, with idx, gap counter, buffer, oTxData, oTxValid, oBusy and oDropCnt all 0, asynchronously.
REQ-026 Reset mid-packet SHALL abort the packet; no remaining bytes SHALL be sent after release.
REQ-027 The first iValid SHALL be honoured on the first rising edge after n_rst deasserts.

Structure
REQ-028 A shared package SHALL hold the FSM state enum (IDLE, SEND, GAP) and default parameter constants (UART_BIT_WIDTH=8, subpacket count 4).
REQ-029 The gap counter SHALL be a sub-module pace_timer (load, count-down, done flag, width $clog2(SUB_GAP_CYCLES+1)).
REQ-030 Idx width SHALL be $clog2(REG_SIZE); there SHALL be no combinational path from iValid to oTxValid.

Verification
REQ-031 With REG_SIZE=36, SUB_GAP_CYCLES=4, iTxReady=1, bytes 0x00..0x23, one iValid: the bench SHALL see bytes in order, with 9 consecutive valids, 4 idle cycles, repeated 4 times, then IDLE with oBusy=0.
REQ-032 The bench SHALL toggle iTxReady randomly and check oTxData/oTxValid hold under backpressure and no byte is lost or duplicated.
REQ-033 The bench SHALL issue 3 iValid strobes mid-packet plus 1 on the final-transfer edge and expect oDropCnt=4 with the packet content unchanged.
REQ-034 The bench SHALL pulse n_rst low after byte 12 and expect all outputs 0 and no further bytes; a new iValid then restarts from byte 0.
REQ-035 With SUB_GAP_CYCLES=0, the bench SHALL expect 36 transfers in 36 consecutive cycles with iTxReady=1.
